// File: rtl/s444_resp_misr.sv
// Response MISR for the s444 stage: folds RESP into a signature per valid pattern and checks it against a golden value.
// Optional TOGGLE_CNT_EN adds sticky per-output toggle coverage (TOG) that also gates PASS.
module s444_resp_misr #(
  parameter int unsigned SIG_W = 16,
  parameter int unsigned CNT_W = 10,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0] SEED = SIG_W'(16'hFFFF)
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             START,
  input  logic [CNT_W-1:0] NPAT,
  input  logic [SIG_W-1:0] GOLD,
  input  logic             VLD,
  input  logic [5:0]       RESP,
`ifdef TOGGLE_CNT_EN
  output logic [5:0]       TOG,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [SIG_W-1:0] SIG,
  output logic [CNT_W-1:0] CNT
);

  localparam int unsigned RESP_W = 6;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] npat_q, npat_d;
  logic [SIG_W-1:0] gold_q, gold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [SIG_W-1:0] sig_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             tog_ok;

`ifdef TOGGLE_CNT_EN
  logic [RESP_W-1:0] tog_q, tog_d;
  logic [RESP_W-1:0] prev_q, prev_d;
  logic              have_prev_q, have_prev_d;
`endif

  // One MISR step: shift, conditional polynomial feedback, inject response
  always_comb begin
    sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0) ^ SIG_W'(RESP);
    cnt_inc  = cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    npat_d  = npat_q;
    gold_d  = gold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    tog_ok  = 1'b1;
`ifdef TOGGLE_CNT_EN
    tog_d       = tog_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
`endif

    case (state_q)
      S_RUN: begin
        if (VLD) begin
          sig_d = sig_next;
          cnt_d = cnt_inc;
`ifdef TOGGLE_CNT_EN
          if (have_prev_q) tog_d = tog_q | (RESP ^ prev_q);
          prev_d      = RESP;
          have_prev_d = 1'b1;
          tog_ok      = (tog_d == {RESP_W{1'b1}});
`endif
          if (cnt_inc == npat_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (sig_next == gold_q) && tog_ok;
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new run
        if (START) begin
          sig_d  = SEED;
          cnt_d  = '0;
          npat_d = NPAT;
          gold_d = GOLD;
          pass_d = 1'b0;
`ifdef TOGGLE_CNT_EN
          tog_d       = '0;
          prev_d      = '0;
          have_prev_d = 1'b0;
          tog_ok      = 1'b0;
`endif
          if (NPAT == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (SEED == GOLD) && tog_ok;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      sig_q   <= '0;
      cnt_q   <= '0;
      npat_q  <= '0;
      gold_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      npat_q  <= npat_d;
      gold_q  <= gold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef TOGGLE_CNT_EN
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      tog_q       <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      tog_q       <= tog_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign TOG = tog_q;
`endif

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign PASS = pass_q;
  assign SIG  = sig_q;
  assign CNT  = cnt_q;

endmodule

// File: tb/tb_s444_resp_misr.sv
// Directed self-checking bench for s444_resp_misr; expected signatures are hand-computed for POLY=16'h1021, SEED=16'hFFFF.
module tb_s444_resp_misr;

`ifdef TOGGLE_CNT_EN
  localparam bit TOGF = 1'b1;
`else
  localparam bit TOGF = 1'b0;
`endif

  logic        CK;
  logic        RSTN;
  logic        START;
  logic [9:0]  NPAT;
  logic [15:0] GOLD;
  logic        VLD;
  logic [5:0]  RESP;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [15:0] SIG;
  logic [9:0]  CNT;
`ifdef TOGGLE_CNT_EN
  logic [5:0]  TOG;
`endif

  int tests_run;
  int tests_failed;

  s444_resp_misr dut (
    .CK    (CK),
    .RSTN  (RSTN),
    .START (START),
    .NPAT  (NPAT),
    .GOLD  (GOLD),
    .VLD   (VLD),
    .RESP  (RESP),
`ifdef TOGGLE_CNT_EN
    .TOG   (TOG),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .PASS  (PASS),
    .SIG   (SIG),
    .CNT   (CNT)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too
  task automatic do_start(input logic [9:0] n, input logic [15:0] g);
    @(negedge CK);
    START = 1'b1;
    NPAT  = n;
    GOLD  = g;
    @(negedge CK);
    START = 1'b0;
  endtask

  task automatic absorb(input logic [5:0] r);
    VLD  = 1'b1;
    RESP = r;
    @(negedge CK);
    VLD  = 1'b0;
    RESP = 6'h00;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RSTN  = 1'b0;
    START = 1'b0;
    NPAT  = '0;
    GOLD  = '0;
    VLD   = 1'b0;
    RESP  = '0;
    #12;
    check_eq("rst_sig", 32'(SIG), 32'h0);
    check_eq("rst_cnt", 32'(CNT), 32'h0);
    check_eq("rst_busy", 32'(BUSY), 32'h0);
    check_eq("rst_done", 32'(DONE), 32'h0);
    check_eq("rst_pass", 32'(PASS), 32'h0);
    @(negedge CK);
    RSTN = 1'b1;
    @(negedge CK);

    // NPAT=0: done immediately with seed signature
    do_start(10'd0, 16'hFFFF);
    check_eq("n0_done", 32'(DONE), 32'h1);
    check_eq("n0_busy", 32'(BUSY), 32'h0);
    check_eq("n0_sig", 32'(SIG), 32'hFFFF);
    check_eq("n0_cnt", 32'(CNT), 32'h0);
    check_eq("n0_pass", 32'(PASS), 32'(!TOGF));

    // NPAT=1, RESP=0 -> EFDF
    do_start(10'd1, 16'hEFDF);
    check_eq("n1_busy", 32'(BUSY), 32'h1);
    check_eq("n1_done0", 32'(DONE), 32'h0);
    check_eq("n1_pass0", 32'(PASS), 32'h0);
    check_eq("n1_sig_seed", 32'(SIG), 32'hFFFF);
    absorb(6'h00);
    check_eq("n1_sig", 32'(SIG), 32'hEFDF);
    check_eq("n1_cnt", 32'(CNT), 32'h1);
    check_eq("n1_done", 32'(DONE), 32'h1);
    check_eq("n1_busyoff", 32'(BUSY), 32'h0);
    check_eq("n1_pass", 32'(PASS), 32'(!TOGF));

    // VLD while DONE is ignored
    absorb(6'h3F);
    check_eq("idle_vld_sig", 32'(SIG), 32'hEFDF);
    check_eq("idle_vld_cnt", 32'(CNT), 32'h1);

    // NPAT=1, RESP=3F -> EFE0, mismatch against EFDF
    do_start(10'd1, 16'hEFDF);
    absorb(6'h3F);
    check_eq("n1f_sig", 32'(SIG), 32'hEFE0);
    check_eq("n1f_done", 32'(DONE), 32'h1);
    check_eq("n1f_pass", 32'(PASS), 32'h0);

    // NPAT=3, gaps of 2 cycles, START pulsed mid-run; three zero patterns -> 8F1F
    do_start(10'd3, 16'h8F1F);
    for (int i = 0; i < 3; i++) begin
      absorb(6'h00);
      check_eq("n3_cnt", 32'(CNT), 32'(i + 1));
      if (i < 2) begin
        check_eq("n3_busy", 32'(BUSY), 32'h1);
        check_eq("n3_notdone", 32'(DONE), 32'h0);
        START = (i == 0);
        NPAT  = 10'd0;
        GOLD  = 16'h0000;
        @(negedge CK);
        START = 1'b0;
        @(negedge CK);
        check_eq("n3_gap_cnt", 32'(CNT), 32'(i + 1));
        check_eq("n3_gap_busy", 32'(BUSY), 32'h1);
        check_eq("n3_gap_done", 32'(DONE), 32'h0);
      end
    end
    check_eq("n3_done", 32'(DONE), 32'h1);
    check_eq("n3_busy_end", 32'(BUSY), 32'h0);
    check_eq("n3_sig", 32'(SIG), 32'h8F1F);
    check_eq("n3_pass", 32'(PASS), 32'(!TOGF));

    // START on the same edge as the final VLD: VLD wins, START ignored
    do_start(10'd1, 16'hEFDF);
    START = 1'b1;
    NPAT  = 10'd5;
    absorb(6'h00);
    START = 1'b0;
    check_eq("coll_done", 32'(DONE), 32'h1);
    check_eq("coll_cnt", 32'(CNT), 32'h1);
    check_eq("coll_sig", 32'(SIG), 32'hEFDF);
    @(negedge CK);
    check_eq("coll_still_done", 32'(DONE), 32'h1);
    check_eq("coll_busy", 32'(BUSY), 32'h0);

    // Async reset mid-run at CNT=2, then a clean run
    do_start(10'd3, 16'h8F1F);
    absorb(6'h00);
    absorb(6'h00);
    check_eq("ar_cnt2", 32'(CNT), 32'h2);
    #2 RSTN = 1'b0;
    #1;
    check_eq("ar_sig", 32'(SIG), 32'h0);
    check_eq("ar_cnt", 32'(CNT), 32'h0);
    check_eq("ar_busy", 32'(BUSY), 32'h0);
    check_eq("ar_done", 32'(DONE), 32'h0);
    check_eq("ar_pass", 32'(PASS), 32'h0);
    @(negedge CK);
    RSTN = 1'b1;
    do_start(10'd1, 16'hEFDF);
    check_eq("ar_seed", 32'(SIG), 32'hFFFF);
    absorb(6'h00);
    check_eq("ar_run_sig", 32'(SIG), 32'hEFDF);
    check_eq("ar_run_done", 32'(DONE), 32'h1);
    check_eq("ar_run_pass", 32'(PASS), 32'(!TOGF));

`ifdef TOGGLE_CNT_EN
    // 00 then 3F -> EFDF, then CF9F^3F = CFA0; every output toggled
    do_start(10'd2, 16'hCFA0);
    check_eq("tog_clr", 32'(TOG), 32'h0);
    absorb(6'h00);
    check_eq("tog_first", 32'(TOG), 32'h0);
    absorb(6'h3F);
    check_eq("tog_all", 32'(TOG), 32'h3F);
    check_eq("tog_all_sig", 32'(SIG), 32'hCFA0);
    check_eq("tog_all_pass", 32'(PASS), 32'h1);
    // 00 then 01 -> CF9E; signature matches but coverage is incomplete
    do_start(10'd2, 16'hCF9E);
    absorb(6'h00);
    absorb(6'h01);
    check_eq("tog_one", 32'(TOG), 32'h01);
    check_eq("tog_one_sig", 32'(SIG), 32'hCF9E);
    check_eq("tog_one_pass", 32'(PASS), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
